// File: rtl/fft_pkg.sv
// Shared FFT definitions: complex operand format, Q1.23 unity and the bit-reversal index helper.
// Used by the input loader, the butterfly datapath and later stages.
package fft_pkg;

    localparam int DW = 24;

    localparam logic signed [DW-1:0] ONE = 24'h7FFFFF;

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

    function automatic logic [31:0] bitrev(input logic [31:0] idx, input int width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < width; i++) begin
            r = (r << 1) | ((idx >> i) & 32'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank sample store with one write port and one synchronous pair-read port.
// Even and odd addresses sit in separate arrays so a single read returns bank[2k] and bank[2k+1].
module fft_pingpong_ram #(
    parameter int N = 64,
    parameter int W = 48
) (
    input  logic                 i_clk,
    input  logic                 i_wr_en,
    input  logic                 i_wr_bank,
    input  logic [$clog2(N)-1:0] i_wr_addr,
    input  logic [W-1:0]         i_wr_data,
    input  logic                 i_rd_en,
    input  logic                 i_rd_bank,
    input  logic [$clog2(N)-2:0] i_rd_pair,
    output logic [W-1:0]         o_rd_even,
    output logic [W-1:0]         o_rd_odd
);

    localparam int AW = $clog2(N);

    logic [W-1:0]  r_mem_even [0:N-1];
    logic [W-1:0]  r_mem_odd  [0:N-1];
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;

    assign w_wr_idx = {i_wr_bank, i_wr_addr[AW-1:1]};
    assign w_rd_idx = {i_rd_bank, i_rd_pair};

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            if (i_wr_addr[0]) begin
                r_mem_odd[w_wr_idx] <= i_wr_data;
            end else begin
                r_mem_even[w_wr_idx] <= i_wr_data;
            end
        end
        if (i_rd_en) begin
            o_rd_even <= r_mem_even[w_rd_idx];
            o_rd_odd  <= r_mem_odd[w_rd_idx];
        end
    end

endmodule

// File: rtl/fft_bitrev_loader.sv
// Radix-2 DIT FFT input stage: stores real samples bit-reversed into ping-pong banks and
// streams stage-0 operand pairs through a registered output with a one-entry skid.
//
// r_state | meaning
// S_IDLE  | output register empty
// S_READ  | output register holds a pair, skid empty
// S_HOLD  | output register and skid both hold pairs (downstream stalled)
module fft_bitrev_loader
    import fft_pkg::*;
#(
    parameter int N  = 64,
    parameter int DW = fft_pkg::DW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DW-1:0]        in_sample,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [2*DW-1:0]      out_num1,
    output logic [2*DW-1:0]      out_num2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [$clog2(N)-2:0] out_pair,
    output logic                 out_last
);

    localparam int LOG2N = $clog2(N);
    localparam int PW    = LOG2N - 1;

    localparam logic [LOG2N-1:0] WR_LAST = LOG2N'(N - 1);
    localparam logic [PW-1:0]    RD_LAST = PW'(N / 2 - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    if (N < 4 || (N & (N - 1)) != 0) begin : g_bad_n
        $error("fft_bitrev_loader: N=%0d must be a power of two >= 4", N);
    end

    logic [LOG2N-1:0] r_wr_cnt;
    logic             r_wr_bank;
    logic [1:0]       r_bank_full;
    logic [PW-1:0]    r_rd_cnt;
    logic             r_rd_bank;
    logic             r_rel_bank;
    logic             r_pipe_valid;
    logic [PW-1:0]    r_pipe_pair;
    logic             r_pipe_last;
    logic [1:0]       r_state;
    logic [2*DW-1:0]  r_out_num1;
    logic [2*DW-1:0]  r_out_num2;
    logic [PW-1:0]    r_out_pair;
    logic             r_out_last;
    logic [2*DW-1:0]  r_skid_num1;
    logic [2*DW-1:0]  r_skid_num2;
    logic [PW-1:0]    r_skid_pair;
    logic             r_skid_last;

    logic             w_wr_en;
    logic [LOG2N-1:0] w_wr_addr;
    logic [2*DW-1:0]  w_wr_data;
    logic             w_fill_done;
    logic             w_pop;
    logic             w_drain_done;
    logic [1:0]       w_occ;
    logic             w_issue;
    logic             w_rd_last;
    logic [2*DW-1:0]  w_ram_even;
    logic [2*DW-1:0]  w_ram_odd;

    assign in_ready     = ~r_bank_full[r_wr_bank];
    assign w_wr_en      = in_valid & in_ready;
    assign w_wr_addr    = LOG2N'(bitrev(32'(r_wr_cnt), LOG2N));
    assign w_wr_data    = {in_sample, {DW{1'b0}}};
    assign w_fill_done  = w_wr_en & (r_wr_cnt == WR_LAST);

    assign out_valid    = (r_state != S_IDLE);
    assign out_num1     = r_out_num1;
    assign out_num2     = r_out_num2;
    assign out_pair     = r_out_pair;
    assign out_last     = r_out_last;
    assign w_pop        = out_valid & out_ready;
    assign w_drain_done = w_pop & r_out_last;

    // Pairs held in output + skid + RAM read latch may never exceed the two output slots.
    assign w_occ     = {1'b0, out_valid} + {1'b0, (r_state == S_HOLD)} + {1'b0, r_pipe_valid};
    assign w_issue   = r_bank_full[r_rd_bank] & (~w_occ[1] | w_pop);
    assign w_rd_last = (r_rd_cnt == RD_LAST);

    fft_pingpong_ram #(
        .N (N),
        .W (2 * DW)
    ) u_ram (
        .i_clk     (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_bank (r_wr_bank),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (w_wr_data),
        .i_rd_en   (w_issue),
        .i_rd_bank (r_rd_bank),
        .i_rd_pair (r_rd_cnt),
        .o_rd_even (w_ram_even),
        .o_rd_odd  (w_ram_odd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_cnt  <= '0;
            r_wr_bank <= 1'b0;
        end else if (w_wr_en) begin
            if (r_wr_cnt == WR_LAST) begin
                r_wr_cnt  <= '0;
                r_wr_bank <= ~r_wr_bank;
            end else begin
                r_wr_cnt <= r_wr_cnt + LOG2N'(1);
            end
        end
    end

    // Fill and drain always target different banks, so both updates may land in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bank_full <= '0;
            r_rel_bank  <= 1'b0;
        end else begin
            if (w_fill_done) begin
                r_bank_full[r_wr_bank] <= 1'b1;
            end
            if (w_drain_done) begin
                r_bank_full[r_rel_bank] <= 1'b0;
                r_rel_bank              <= ~r_rel_bank;
            end
        end
    end

    // The read pointer moves to the next bank at the last issue, ahead of the release,
    // so back-to-back frames stream without a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_cnt     <= '0;
            r_rd_bank    <= 1'b0;
            r_pipe_valid <= 1'b0;
            r_pipe_pair  <= '0;
            r_pipe_last  <= 1'b0;
        end else begin
            r_pipe_valid <= w_issue;
            if (w_issue) begin
                r_pipe_pair <= r_rd_cnt;
                r_pipe_last <= w_rd_last;
                if (w_rd_last) begin
                    r_rd_cnt  <= '0;
                    r_rd_bank <= ~r_rd_bank;
                end else begin
                    r_rd_cnt <= r_rd_cnt + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_out_num1  <= '0;
            r_out_num2  <= '0;
            r_out_pair  <= '0;
            r_out_last  <= 1'b0;
            r_skid_num1 <= '0;
            r_skid_num2 <= '0;
            r_skid_pair <= '0;
            r_skid_last <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_pipe_valid) begin
                        r_out_num1 <= w_ram_even;
                        r_out_num2 <= w_ram_odd;
                        r_out_pair <= r_pipe_pair;
                        r_out_last <= r_pipe_last;
                        r_state    <= S_READ;
                    end
                end
                S_READ: begin
                    if (r_pipe_valid) begin
                        if (out_ready) begin
                            r_out_num1 <= w_ram_even;
                            r_out_num2 <= w_ram_odd;
                            r_out_pair <= r_pipe_pair;
                            r_out_last <= r_pipe_last;
                        end else begin
                            r_skid_num1 <= w_ram_even;
                            r_skid_num2 <= w_ram_odd;
                            r_skid_pair <= r_pipe_pair;
                            r_skid_last <= r_pipe_last;
                            r_state     <= S_HOLD;
                        end
                    end else if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_out_num1 <= r_skid_num1;
                        r_out_num2 <= r_skid_num2;
                        r_out_pair <= r_skid_pair;
                        r_out_last <= r_skid_last;
                        r_state    <= S_READ;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_bitrev_loader.sv
// Bench for fft_bitrev_loader at N=8: directed frames, backpressure, reset and a random soak,
// checked against a frame-level bit-reversal model plus a few literal expectations.
`timescale 1ns/1ps
module tb_fft_bitrev_loader;

    localparam int NT  = 8;
    localparam int DWT = 24;
    localparam int LG  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [23:0]   in_sample;
    logic          in_valid;
    logic          in_ready;
    logic [47:0]   out_num1;
    logic [47:0]   out_num2;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_pair;
    logic          out_last;

    fft_bitrev_loader #(.N(NT), .DW(DWT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_sample (in_sample),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_num1  (out_num1),
        .out_num2  (out_num2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pair  (out_pair),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Model state: current partial frame, expected pairs, and a log of delivered operands.
    logic [23:0] frame_q[$];
    logic [98:0] exp_q[$];
    logic [23:0] log_q[$];
    int          pop_cnt;
    int          acc_cnt;
    int          first_pop;
    int          last_pop;
    logic        prev_stall = 1'b0;
    logic [98:0] prev_word;

    int t1_ord[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    function automatic int brv(input int x, input int bits);
        int r;
        r = 0;
        for (int i = 0; i < bits; i++) begin
            r = r * 2 + ((x >> i) % 2);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [98:0] cur;
        cur = {out_num1, out_num2, out_pair, out_last};
        if (rst) begin
            frame_q.delete();
            exp_q.delete();
            prev_stall = 1'b0;
            chk("rst_outputs", {out_valid, cur}, '0);
            chk("rst_in_ready", in_ready, 1);
        end else begin
            if (prev_stall) chk("hold_stable", cur, prev_word);
            if (in_valid && in_ready) begin
                acc_cnt++;
                frame_q.push_back(in_sample);
                if (frame_q.size() == NT) begin
                    for (int k = 0; k < NT / 2; k++) begin
                        logic [47:0] a;
                        logic [47:0] b;
                        a = {frame_q[brv(2 * k, LG)], 24'h0};
                        b = {frame_q[brv(2 * k + 1, LG)], 24'h0};
                        exp_q.push_back({a, b, 2'(k), (k == NT / 2 - 1)});
                    end
                    frame_q.delete();
                end
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_pair: got out_valid=1 expected no pair pending");
                end else begin
                    chk("pair", cur, exp_q[0]);
                    if (out_ready) begin
                        log_q.push_back(out_num1[47:24]);
                        log_q.push_back(out_num2[47:24]);
                        pop_cnt++;
                        if (first_pop < 0) first_pop = cyc;
                        last_pop = cyc;
                        void'(exp_q.pop_front());
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = cur;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        log_q.delete();
        pop_cnt   = 0;
        acc_cnt   = 0;
        first_pop = -1;
        last_pop  = -1;
    endtask

    task automatic send(input logic [23:0] s, output int stalls);
        int   n;
        logic hs;
        n         = 0;
        stalls    = 0;
        in_sample = s;
        in_valid  = 1'b1;
        do begin
            hs = in_ready;
            step();
            if (!hs) stalls++;
            n++;
        end while (!hs && n < 100);
        if (!hs) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 for %0d clk expected acceptance", n);
        end
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout: got out_valid=0 after %0d clk expected 1", n);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 500) begin
            step();
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic check_order(input int base, input int off);
        for (int i = 0; i < 8; i++) begin
            if (off + i < log_q.size()) chk("order", log_q[off + i], 24'(base + t1_ord[i]));
            else chk("order_missing", log_q.size(), off + 8);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1);
    end

    initial begin
        int          st;
        int          tot;
        int          h;
        int          n;
        logic [23:0] s4 [8];

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sample = '0;
        out_ready = 1'b0;
        clear_stats();
        repeat (3) step();
        rst = 1'b0;
        step();

        // T1: single frame, literal order and 2-clk latency
        out_ready = 1'b1;
        clear_stats();
        for (int i = 0; i < 8; i++) send(24'(i), st);
        in_valid = 1'b0;
        h = cyc;
        wait_valid();
        chk("t1_latency", cyc - h, 2);
        wait_drain();
        chk("t1_pairs", pop_cnt, 4);
        check_order(0, 0);

        // T2: four back-to-back frames
        clear_stats();
        tot = 0;
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 8; i++) begin
                send(24'(32 + 16 * f + i), st);
                tot += st;
            end
        end
        in_valid = 1'b0;
        wait_drain();
        chk("t2_in_ready_stalls", tot, 0);
        chk("t2_pairs", pop_cnt, 16);
        for (int f = 0; f < 4; f++) check_order(32 + 16 * f, 8 * f);

        // T3: both banks fill under backpressure, then drain
        out_ready = 1'b0;
        clear_stats();
        for (int i = 0; i < 16; i++) send(24'(100 + i), st);
        in_valid = 1'b0;
        chk("t3_in_ready_low", in_ready, 0);
        repeat (4) step();
        chk("t3_valid_held", out_valid, 1);
        chk("t3_num1_held", out_num1, {24'd100, 24'd0});
        chk("t3_num2_held", out_num2, {24'd104, 24'd0});
        chk("t3_still_blocked", in_ready, 0);
        out_ready = 1'b1;
        n = 0;
        while (pop_cnt < 4 && n < 20) begin
            step();
            n++;
            if (pop_cnt == 3) chk("t3_in_ready_before_4th", in_ready, 0);
        end
        chk("t3_in_ready_after_4th", in_ready, 1);
        wait_drain();
        chk("t3_pairs", pop_cnt, 8);
        chk("t3_burst_span", last_pop - first_pop, 7);
        check_order(100, 0);
        check_order(108, 8);

        // T4: full-scale extremes pass through untouched
        clear_stats();
        for (int i = 0; i < 8; i++) s4[i] = 24'(i + 1);
        s4[0] = 24'h800000;
        s4[4] = fft_pkg::ONE;
        for (int i = 0; i < 8; i++) send(s4[i], st);
        in_valid = 1'b0;
        h = cyc;
        wait_valid();
        chk("t4_latency", cyc - h, 2);
        chk("t4_num1", out_num1, 48'h800000_000000);
        chk("t4_num2", out_num2, 48'h7FFFFF_000000);
        wait_drain();

        // T5: reset mid-frame discards the partial frame
        clear_stats();
        for (int i = 0; i < 3; i++) send(24'(300 + i), st);
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        clear_stats();
        for (int i = 0; i < 8; i++) send(24'(200 + i), st);
        in_valid = 1'b0;
        wait_drain();
        chk("t5_pairs", pop_cnt, 4);
        check_order(200, 0);

        // T6: random valid/ready soak
        clear_stats();
        for (int c = 0; c < 6000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sample = 24'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        chk("t6_no_loss", pop_cnt, (acc_cnt / 8) * 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
